arm_ctrl_exmem: RTL and testbench

Front-end control slice of the 5-stage ARM pipeline. It combines three parts:
- the PC+4 incrementer;
- the ID-stage combinational control decoder, which turns a 32-bit ARM instruction into pipeline control signals and a 3-character ASCII mnemonic;
- the EX/MEM control pipeline register.

It sits between instruction fetch/decode and the memory stage.

---
 rtl/arm_ctrl_exmem_pkg.sv | 69 ++++++
 rtl/arm_ctrl_decoder.sv | 67 ++++++
 rtl/arm_ctrl_exmem.sv | 71 +++++++
 tb/tb_arm_ctrl_exmem.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_exmem_pkg.sv
// Shared encodings for the ARM front-end control slice: ALU opcodes, addressing
// modes, instruction-class fields and the ASCII mnemonic helper.
package arm_ctrl_exmem_pkg;

    localparam logic [31:0] PC_INC = 32'd4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_EOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_RSB = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ADC = 4'b0101;
    localparam logic [3:0] ALU_SBC = 4'b0110;
    localparam logic [3:0] ALU_RSC = 4'b0111;
    localparam logic [3:0] ALU_TST = 4'b1000;
    localparam logic [3:0] ALU_TEQ = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_CMN = 4'b1011;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_BIC = 4'b1110;
    localparam logic [3:0] ALU_MVN = 4'b1111;

    localparam logic [1:0] AM_ROT_IMM = 2'b00;
    localparam logic [1:0] AM_SHIFT   = 2'b01;
    localparam logic [1:0] AM_IMM_OFF = 2'b10;
    localparam logic [1:0] AM_REG_OFF = 2'b11;

    // Instruction-class fields: [27:26] for DP / LS, [27:25] for branch / extra space
    localparam logic [1:0] CLS_DP     = 2'b00;
    localparam logic [1:0] CLS_LS     = 2'b01;
    localparam logic [2:0] CLS_BRANCH = 3'b101;
    localparam logic [2:0] CLS_EXTRA  = 3'b000;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h42;
    localparam logic [7:0] CH_L     = 8'h4C;

    localparam logic [23:0] MN_NOP = "NOP";
    localparam logic [23:0] MN_UND = "UND";
    localparam logic [23:0] MN_LDR = "LDR";
    localparam logic [23:0] MN_STR = "STR";
    localparam logic [23:0] MN_LDB = "LDB";
    localparam logic [23:0] MN_STB = "STB";

    function automatic logic [23:0] dp_mnemonic(input logic [3:0] opcode);
        logic [23:0] mn;
        case (opcode)
            ALU_AND: mn = "AND";
            ALU_EOR: mn = "EOR";
            ALU_SUB: mn = "SUB";
            ALU_RSB: mn = "RSB";
            ALU_ADD: mn = "ADD";
            ALU_ADC: mn = "ADC";
            ALU_SBC: mn = "SBC";
            ALU_RSC: mn = "RSC";
            ALU_TST: mn = "TST";
            ALU_TEQ: mn = "TEQ";
            ALU_CMP: mn = "CMP";
            ALU_CMN: mn = "CMN";
            ALU_ORR: mn = "ORR";
            ALU_MOV: mn = "MOV";
            ALU_BIC: mn = "BIC";
            default: mn = "MVN";
        endcase
        return mn;
    endfunction

endpackage

// File: rtl/arm_ctrl_decoder.sv
// ID-stage combinational decoder: ARM instruction word to pipeline controls
// and a 3-character ASCII mnemonic. Condition field is ignored.
module arm_ctrl_decoder
    import arm_ctrl_exmem_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        s_bit_o,
    output logic        load_instr_o,
    output logic        rf_enable_o,
    output logic        b_instr_o,
    output logic        bl_instr_o,
    output logic        load_store_instr_o,
    output logic        size_o,
    output logic [1:0]  shift_am_o,
    output logic [3:0]  alu_op_o,
    output logic [23:0] mnemonic_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // priority chain leaves one unassigned and infers a latch.
        s_bit_o            = 1'b0;
        load_instr_o       = 1'b0;
        rf_enable_o        = 1'b0;
        b_instr_o          = 1'b0;
        bl_instr_o         = 1'b0;
        load_store_instr_o = 1'b0;
        size_o             = 1'b0;
        shift_am_o         = AM_ROT_IMM;
        alu_op_o           = ALU_AND;
        mnemonic_o         = MN_UND;

        if (instr_i == 32'h0) begin
            mnemonic_o = MN_NOP;
        end else if (instr_i[27:25] == CLS_EXTRA && instr_i[7] && instr_i[4]) begin
            mnemonic_o = MN_UND;
        end else if (instr_i[27:26] == CLS_DP) begin
            alu_op_o    = instr_i[24:21];
            s_bit_o     = instr_i[20];
            // Compare/test opcodes (10xx) only set flags
            rf_enable_o = (instr_i[24:23] != 2'b10);
            shift_am_o  = instr_i[25] ? AM_ROT_IMM : AM_SHIFT;
            mnemonic_o  = dp_mnemonic(instr_i[24:21]);
        end else if (instr_i[27:26] == CLS_LS) begin
            load_store_instr_o = 1'b1;
            load_instr_o       = instr_i[20];
            rf_enable_o        = instr_i[20];
            size_o             = instr_i[22];
            alu_op_o           = instr_i[23] ? ALU_ADD : ALU_SUB;
            shift_am_o         = instr_i[25] ? AM_REG_OFF : AM_IMM_OFF;
            case ({instr_i[20], instr_i[22]})
                2'b10:   mnemonic_o = MN_LDR;
                2'b11:   mnemonic_o = MN_LDB;
                2'b00:   mnemonic_o = MN_STR;
                default: mnemonic_o = MN_STB;
            endcase
        end else if (instr_i[27:25] == CLS_BRANCH) begin
            b_instr_o   = 1'b1;
            bl_instr_o  = instr_i[24];
            rf_enable_o = instr_i[24];
            alu_op_o    = ALU_ADD;
            shift_am_o  = AM_ROT_IMM;
            mnemonic_o  = instr_i[24] ? {CH_B, CH_L, CH_SPACE} : {CH_B, CH_SPACE, CH_SPACE};
        end
    end

endmodule

// File: rtl/arm_ctrl_exmem.sv
// ARM front-end control slice: PC+4 adder, ID-stage decoder and the
// EX/MEM control pipeline register.
module arm_ctrl_exmem
    import arm_ctrl_exmem_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PC,
    output logic [31:0] NextPC,
    input  logic [31:0] instruction,
    output logic        ID_S_bit,
    output logic        ID_load_instr,
    output logic        ID_RF_enable,
    output logic        ID_B_instr,
    output logic        ID_BL_instr,
    output logic        ID_load_store_instr,
    output logic        ID_size,
    output logic [1:0]  ID_shift_AM,
    output logic [3:0]  ID_alu_op,
    output logic [7:0]  ID_mnemonic0,
    output logic [7:0]  ID_mnemonic1,
    output logic [7:0]  ID_mnemonic2,
    input  logic        EX_load_store_instr,
    input  logic        EX_size,
    input  logic        EX_RF_enable,
    input  logic        EX_load_instr,
    output logic        MEM_load_store_instr,
    output logic        MEM_size,
    output logic        MEM_RF_enable,
    output logic        MEM_load_instr
);

    logic [23:0] mnemonic;
    logic [3:0]  mem_d;
    logic [3:0]  mem_q;

    assign NextPC = PC + PC_INC;

    arm_ctrl_decoder u_decoder (
        .instr_i            (instruction),
        .s_bit_o            (ID_S_bit),
        .load_instr_o       (ID_load_instr),
        .rf_enable_o        (ID_RF_enable),
        .b_instr_o          (ID_B_instr),
        .bl_instr_o         (ID_BL_instr),
        .load_store_instr_o (ID_load_store_instr),
        .size_o             (ID_size),
        .shift_am_o         (ID_shift_AM),
        .alu_op_o           (ID_alu_op),
        .mnemonic_o         (mnemonic)
    );

    assign ID_mnemonic0 = mnemonic[23:16];
    assign ID_mnemonic1 = mnemonic[15:8];
    assign ID_mnemonic2 = mnemonic[7:0];

    assign mem_d = {EX_load_store_instr, EX_size, EX_RF_enable, EX_load_instr};

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignment so every flop samples its pre-edge
        // input, independent of process ordering.
        if (Reset) begin
            mem_q <= 4'b0000;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign {MEM_load_store_instr, MEM_size, MEM_RF_enable, MEM_load_instr} = mem_q;

endmodule

// File: tb/tb_arm_ctrl_exmem.sv
// Directed self-checking bench for arm_ctrl_exmem: adder wrap, decoder classes
// and EX/MEM register latency and reset behaviour.
module tb_arm_ctrl_exmem;

    logic        Clk;
    logic        Reset;
    logic [31:0] PC;
    logic [31:0] NextPC;
    logic [31:0] instruction;
    logic        ID_S_bit, ID_load_instr, ID_RF_enable, ID_B_instr, ID_BL_instr;
    logic        ID_load_store_instr, ID_size;
    logic [1:0]  ID_shift_AM;
    logic [3:0]  ID_alu_op;
    logic [7:0]  ID_mnemonic0, ID_mnemonic1, ID_mnemonic2;
    logic        EX_load_store_instr, EX_size, EX_RF_enable, EX_load_instr;
    logic        MEM_load_store_instr, MEM_size, MEM_RF_enable, MEM_load_instr;

    int checks   = 0;
    int failures = 0;

    arm_ctrl_exmem dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .PC                   (PC),
        .NextPC               (NextPC),
        .instruction          (instruction),
        .ID_S_bit             (ID_S_bit),
        .ID_load_instr        (ID_load_instr),
        .ID_RF_enable         (ID_RF_enable),
        .ID_B_instr           (ID_B_instr),
        .ID_BL_instr          (ID_BL_instr),
        .ID_load_store_instr  (ID_load_store_instr),
        .ID_size              (ID_size),
        .ID_shift_AM          (ID_shift_AM),
        .ID_alu_op            (ID_alu_op),
        .ID_mnemonic0         (ID_mnemonic0),
        .ID_mnemonic1         (ID_mnemonic1),
        .ID_mnemonic2         (ID_mnemonic2),
        .EX_load_store_instr  (EX_load_store_instr),
        .EX_size              (EX_size),
        .EX_RF_enable         (EX_RF_enable),
        .EX_load_instr        (EX_load_instr),
        .MEM_load_store_instr (MEM_load_store_instr),
        .MEM_size             (MEM_size),
        .MEM_RF_enable        (MEM_RF_enable),
        .MEM_load_instr       (MEM_load_instr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Control bundle: {S, load, RF_en, B, BL, load_store, size, AM[1:0], alu_op[3:0]}
    task automatic check_dec(input string tag, input logic [31:0] instr,
                             input logic [12:0] exp_ctrl, input logic [23:0] exp_mn);
        instruction = instr;
        #1;
        check({tag, "_ctrl"},
              {19'd0, ID_S_bit, ID_load_instr, ID_RF_enable, ID_B_instr, ID_BL_instr,
               ID_load_store_instr, ID_size, ID_shift_AM, ID_alu_op},
              {19'd0, exp_ctrl});
        check({tag, "_mnem"}, {8'd0, ID_mnemonic0, ID_mnemonic1, ID_mnemonic2}, {8'd0, exp_mn});
    endtask

    function automatic logic [31:0] mem_bus();
        return {28'd0, MEM_load_store_instr, MEM_size, MEM_RF_enable, MEM_load_instr};
    endfunction

    task automatic set_ex(input logic [3:0] v);
        {EX_load_store_instr, EX_size, EX_RF_enable, EX_load_instr} = v;
    endtask

    initial begin
        Reset       = 1'b1;
        PC          = 32'h0;
        instruction = 32'h0;
        set_ex(4'b1111);

        // Adder
        #1;
        check("pc_zero", NextPC, 32'h4);
        PC = 32'hFFFF_FFFC;
        #1;
        check("pc_wrap", NextPC, 32'h0);
        PC = 32'h1234_5678;
        #1;
        check("pc_mid", NextPC, 32'h1234_567C);

        // Decoder
        check_dec("add_imm", 32'hE281_1001, 13'b0_0_1_0_0_0_0_00_0100, "ADD");
        check_dec("cmp_reg", 32'hE153_0004, 13'b1_0_0_0_0_0_0_01_1010, "CMP");
        check_dec("tst_reg", 32'hE110_0001, 13'b1_0_0_0_0_0_0_01_1000, "TST");
        check_dec("mvns_imm", 32'hE3F0_0000, 13'b1_0_1_0_0_0_0_00_1111, "MVN");
        check_dec("ldrb",    32'hE5D1_2000, 13'b0_1_1_0_0_1_1_10_0100, "LDB");
        check_dec("str",     32'hE581_2000, 13'b0_0_0_0_0_1_0_10_0100, "STR");
        check_dec("ldr_sub_reg", 32'hE711_2003, 13'b0_1_1_0_0_1_0_11_0010, "LDR");
        check_dec("strb_sub", 32'hE541_2000, 13'b0_0_0_0_0_1_1_10_0010, "STB");
        check_dec("bl",      32'hEB00_0004, 13'b0_0_1_1_1_0_0_00_0100, "BL ");
        check_dec("b",       32'hEA00_0004, 13'b0_0_0_1_0_0_0_00_0100, "B  ");
        check_dec("nop",     32'h0000_0000, 13'b0, "NOP");
        check_dec("mul_und", 32'hE001_0391, 13'b0, "UND");
        check_dec("cop_und", 32'hEE00_0000, 13'b0, "UND");

        // EX/MEM register: reset with inputs high
        @(posedge Clk);
        #1;
        check("mem_reset", mem_bus(), 32'h0);
        Reset = 1'b0;
        #1;
        check("mem_hold_pre", mem_bus(), 32'h0);
        @(posedge Clk);
        #1;
        check("mem_load_ones", mem_bus(), 32'hF);

        // Reset mid-stream: holds until the edge, then clears
        Reset = 1'b1;
        #1;
        check("mem_rst_pre", mem_bus(), 32'hF);
        @(posedge Clk);
        #1;
        check("mem_rst_post", mem_bus(), 32'h0);
        Reset = 1'b0;

        // Distinct per-bit patterns, toggled between edges
        set_ex(4'b1010);
        @(posedge Clk);
        #1;
        check("mem_1010", mem_bus(), 32'hA);
        set_ex(4'b0101);
        #3;
        check("mem_between", mem_bus(), 32'hA);
        set_ex(4'b0011);
        #1;
        check("mem_between2", mem_bus(), 32'hA);
        @(posedge Clk);
        #1;
        check("mem_0011", mem_bus(), 32'h3);
        set_ex(4'b0100);
        @(posedge Clk);
        #1;
        check("mem_0100", mem_bus(), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
